// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
// Optional signed/unsigned select is enabled in the top with MULT_SIGNED_SELECT_EN.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Iteration counter width; must hold WIDTH-1.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/add_sub_n.sv
// N-bit add/subtract with an extra result bit; operands zero- or sign-extended.
module add_sub_n #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         ext_signed,
  output logic [N:0]   sum
);

  logic [N:0] a_x;
  logic [N:0] b_x;

  assign a_x = {ext_signed & a[N-1], a};
  assign b_x = {ext_signed & b[N-1], b};
  assign sum = sub ? (a_x - b_x) : (a_x + b_x);

endmodule

// File: rtl/multiplier_seq_param.sv
// Sequential shift-add multiplier, product held in A:B for chaining.
// Define MULT_SIGNED_SELECT_EN to add the Signed_Mode port (unsigned mode when 0).
module multiplier_seq_param
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Load_Clear,
  input  logic               Run,
  input  logic [WIDTH-1:0]   Din,
`ifdef MULT_SIGNED_SELECT_EN
  input  logic               Signed_Mode,
`endif
  output logic [WIDTH-1:0]   Aval,
  output logic [WIDTH-1:0]   Bval,
  output logic               Xval,
  output logic [2*WIDTH-1:0] Prod,
  output logic               Busy,
  output logic               Done
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   s_q;
  logic               x_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               run_low_q;
  logic               mode_signed;

  logic               run_rise;
  logic               last_iter;
  logic               do_load;
  logic               do_start;
  logic               do_step;
  logic               busy_d;
  logic               done_d;
  logic [WIDTH-1:0]   addend;
  logic               add_sub;
  logic [WIDTH:0]     sum;

  // run_low_q is 0 out of reset, so a Run held through reset must fall before it counts.
  assign run_rise  = Run & run_low_q;
  assign last_iter = (cnt_q == '0);

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!Load_Clear && run_rise) state_d = CALC;
      CALC:    if (last_iter) state_d = HOLD;
      HOLD:    if (!Run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    do_load  = 1'b0;
    do_start = 1'b0;
    do_step  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      do_load  = Load_Clear;
      do_start = !Load_Clear && run_rise;
    end
    if (state_q == CALC) begin
      do_step = 1'b1;
      done_d  = last_iter;
    end
    busy_d = (state_d == CALC);
  end

`ifdef MULT_SIGNED_SELECT_EN
  always_ff @(posedge Clk) begin
    if (Reset)         mode_signed <= 1'b0;
    else if (do_start) mode_signed <= Signed_Mode;
  end
`else
  assign mode_signed = 1'b1;
`endif

  // Final signed iteration subtracts: the multiplier's top bit carries negative weight.
  assign addend  = b_q[0] ? s_q : '0;
  assign add_sub = b_q[0] & last_iter & mode_signed;

  add_sub_n #(.N(WIDTH)) u_add_sub (
    .a          (a_q),
    .b          (addend),
    .sub        (add_sub),
    .ext_signed (mode_signed),
    .sum        (sum)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      x_q       <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      run_low_q <= 1'b0;
    end else begin
      run_low_q <= ~Run;
      busy_q    <= busy_d;
      done_q    <= done_d;
      if (do_load) begin
        a_q <= '0;
        x_q <= 1'b0;
        b_q <= Din;
      end else if (do_start) begin
        s_q   <= Din;
        a_q   <= '0;
        x_q   <= 1'b0;
        cnt_q <= CNT_W'(WIDTH - 1);
      end else if (do_step) begin
        x_q <= sum[WIDTH];
        a_q <= {sum[WIDTH], sum[WIDTH-1:1]};
        b_q <= {sum[0], b_q[WIDTH-1:1]};
        if (!last_iter) cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign Xval = x_q;
  assign Prod = {a_q, b_q};
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_multiplier_seq_param.sv
// Self-checking bench for multiplier_seq_param: directed cases plus random traffic vs a reference model.
module tb_multiplier_seq_param;

  localparam int unsigned W = 8;

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic           Load_Clear = 1'b0;
  logic           Run = 1'b0;
  logic [W-1:0]   Din = '0;
  logic           Signed_Mode = 1'b1;
  logic [W-1:0]   Aval;
  logic [W-1:0]   Bval;
  logic           Xval;
  logic [2*W-1:0] Prod;
  logic           Busy;
  logic           Done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 Clk = ~Clk;

  multiplier_seq_param #(.WIDTH(W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Load_Clear (Load_Clear),
    .Run        (Run),
    .Din        (Din),
`ifdef MULT_SIGNED_SELECT_EN
    .Signed_Mode(Signed_Mode),
`endif
    .Aval       (Aval),
    .Bval       (Bval),
    .Xval       (Xval),
    .Prod       (Prod),
    .Busy       (Busy),
    .Done       (Done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference product: extend both operands to 2W bits and multiply.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic sgn);
    logic [2*W-1:0] ex;
    logic [2*W-1:0] ey;
    ex = sgn ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
    ey = sgn ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
    return ex * ey;
  endfunction

  function automatic logic cur_mode();
`ifdef MULT_SIGNED_SELECT_EN
    return Signed_Mode;
`else
    return 1'b1;
`endif
  endfunction

  // Transaction-level model: whole product computed at accept, revealed after W steps.
  logic [W-1:0]   m_a = '0;
  logic [W-1:0]   m_b = '0;
  logic           m_x = 1'b0;
  logic           m_busy = 1'b0;
  logic           m_done = 1'b0;
  logic           m_hold = 1'b0;
  logic           m_seen_low = 1'b0;
  logic [2*W-1:0] m_pend = '0;
  int             m_left = 0;

  always @(posedge Clk) begin
    if (Reset) begin
      m_a <= '0; m_b <= '0; m_x <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
      m_hold <= 1'b0; m_seen_low <= 1'b0; m_left <= 0;
    end else begin
      m_seen_low <= !Run;
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_hold <= 1'b1;
          m_done <= 1'b1;
          m_a    <= m_pend[2*W-1:W];
          m_b    <= m_pend[W-1:0];
          m_x    <= m_pend[2*W-1];
        end
        m_left <= m_left - 1;
      end else if (m_hold) begin
        if (!Run) m_hold <= 1'b0;
      end else if (Load_Clear) begin
        m_a <= '0; m_x <= 1'b0; m_b <= Din;
      end else if (Run && m_seen_low) begin
        m_busy <= 1'b1;
        m_left <= W;
        m_pend <= ref_mul(m_b, Din, cur_mode());
      end
    end
  end

  // Compare every cycle; the A:B:X datapath is only meaningful outside a calculation.
  always @(negedge Clk) begin
    if (chk_en) begin
      check("busy", 64'(Busy), 64'(m_busy));
      check("done", 64'(Done), 64'(m_done));
      if (!m_busy) begin
        check("aval", 64'(Aval), 64'(m_a));
        check("bval", 64'(Bval), 64'(m_b));
        check("xval", 64'(Xval), 64'(m_x));
        check("prod", 64'(Prod), 64'({m_a, m_b}));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1; Run = 1'b0; Load_Clear = 1'b0;
    tick(2);
    Reset = 1'b0;
    tick(1);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    Load_Clear = 1'b1; Din = v;
    tick(1);
    Load_Clear = 1'b0;
  endtask

  task automatic run_mult(input logic [W-1:0] s, output int lat);
    Din = s; Run = 1'b1; lat = 0;
    do begin
      tick(1);
      lat++;
    end while (Done !== 1'b1 && lat < 40);
    Run = 1'b0;
    tick(2);
  endtask

  initial begin
    int lat;
    int dones;
    int busy_cnt;

    tick(1);
    chk_en = 1'b1;
    do_reset();
    check("reset_prod", 64'(Prod), 64'h0);
    check("reset_busy", 64'({Busy, Done, Xval}), 64'h0);

    do_load(8'hC5);
    run_mult(8'h07, lat);
    check("latency", 64'(lat), 64'd9);
    check("c5x07", 64'(Prod), 64'hFE63);
    check("c5x07_x", 64'(Xval), 64'h1);
    run_mult(8'h07, lat);
    check("chain1", 64'(Prod), 64'h02B5);
    run_mult(8'h07, lat);
    check("chain2", 64'(Prod), 64'hFDF3);

    do_load(8'h80);
    run_mult(8'h80, lat);
    check("min_x_min", 64'(Prod), 64'h4000);
    do_load(8'h00);
    run_mult(8'hFF, lat);
    check("zero_x_ff", 64'(Prod), 64'h0000);

    // Reset three iterations into a calculation, with Run still high afterwards.
    do_load(8'h05);
    Din = 8'h03; Run = 1'b1;
    tick(4);
    Reset = 1'b1;
    tick(1);
    check("midcalc_reset", 64'({Prod, Xval, Busy, Done}), 64'h0);
    Reset = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (Busy) busy_cnt++;
    end
    check("no_restart", 64'(busy_cnt), 64'd0);
    Run = 1'b0;
    tick(1);

    // Run held long, Load_Clear poked mid-calculation.
    do_load(8'h12);
    Din = 8'h34; Run = 1'b1; dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (Done) dones++;
      if (i == 2) begin Load_Clear = 1'b1; Din = 8'hAA; end
      if (i == 3) Load_Clear = 1'b0;
    end
    Run = 1'b0;
    tick(2);
    check("one_done", 64'(dones), 64'd1);
    check("lc_in_calc", 64'(Prod), 64'h03A8);

`ifdef MULT_SIGNED_SELECT_EN
    Signed_Mode = 1'b0;
    do_load(8'hFF);
    run_mult(8'hFF, lat);
    check("unsigned_ff", 64'(Prod), 64'hFE01);
    Signed_Mode = 1'b1;
`endif

    // Random traffic; the per-cycle compare carries the checking.
    dones = 0;
    for (int i = 0; i < 3000; i++) begin
      Reset      = ($urandom_range(0, 199) == 0);
      Load_Clear = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 5) == 0) Run = ~Run;
      Din = W'($urandom);
`ifdef MULT_SIGNED_SELECT_EN
      Signed_Mode = 1'($urandom);
`endif
      tick(1);
      if (Done) dones++;
    end
    check("random_done_seen", 64'(dones > 20), 64'h1);

    Reset = 1'b0; Run = 1'b0; Load_Clear = 1'b0;
    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplier_seq_param.md
Name: multiplier_seq_param

Overview:
- Parametrised sequential shift-add multiplier core; next generation of the fixed 8-bit lab multiplier.
- Computes S*B over WIDTH iterations using register A (upper half), register B (lower half) and sign-extension bit X.
- Product stays in A:B so repeated Run presses chain multiplications.
- Sits under the board toplevel, which drives switches, buttons and hex display; also usable stand-alone through the Busy/Done handshake.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Load_Clear  in  1  level; when idle, clears A and X and loads B from Din.
- Run  in  1  level; a rising edge, sampled internally, starts one multiplication.
- Din  in  WIDTH  operand input; loaded into B by Load_Clear, latched as S at Run accept.
- Aval  out  WIDTH  register A.
- Bval  out  WIDTH  register B.
- Xval  out  1  sign-extension bit X.
- Prod  out  2*WIDTH  {Aval,Bval}.
- Busy  out  1  high during the CALC state.
- Done  out  1  one-cycle pulse when the result is valid.

Behaviour:
- Reset:
  - A, B, X, S, counter, Done and Busy all go to 0; state goes to IDLE; Run edge register goes to 0.
  - Reset wins over everything, including mid-CALC; a partial product is discarded.
- States:
  - IDLE:
    - If Load_Clear=1: A<=0, X<=0, B<=Din.
    - Else, on a Run rise (Run=1 and previous Run=0): S<=Din, A<=0, X<=0, cnt<=WIDTH-1, go to CALC.
    - Load_Clear has priority over a simultaneous Run rise; that Run edge is consumed and ignored.
  - CALC, one iteration per clock:
    - If B[0]=1 and cnt≠0: sum = {A[W-1],A} + {S[W-1],S}.
    - If B[0]=1 and cnt=0 (final iteration): sum = {A[W-1],A} − {S[W-1],S}.
    - If B[0]=0: sum = {A[W-1],A}.
    - All arithmetic is WIDTH+1 bits; overflow is discarded.
    - Then arithmetic right shift of {X,A,B}: X<=sum[W], A<={sum[W],sum[W-1:1]}, B<={sum[0],B[W-1:1]}.
    - At cnt=0 go to HOLD; otherwise cnt<=cnt-1.
  - HOLD:
    - Done=1 for exactly the entry cycle.
    - Stay while Run=1; return to IDLE when Run=0.
- Latency: Run rise seen → Done pulse is WIDTH+1 clocks; Prod is stable from the Done cycle onward.
- Load_Clear and Run are ignored in CALC and HOLD; a Run held high never restarts.
- Chaining: a second Run with no Load_Clear multiplies the current B (low half of the previous product) by the new S.
- Prod is a signed 2*WIDTH two's-complement result; all WIDTH-bit signed operand pairs are exact, including −2^(W−1) × −2^(W−1).

Optional Feature:
- Macro: MULT_SIGNED_SELECT_EN.
- When defined, adds input port Signed_Mode (1 bit), sampled at Run accept and held through CALC.
  - Signed_Mode=1: behaviour as above.
  - Signed_Mode=0: unsigned mode. S is zero-extended, A is zero-extended (0 instead of A[W-1]) in the sum, the final iteration adds instead of subtracting, and X is the carry out.
- When undefined: no port; always signed.

Decomposition:
- Package mult_pkg holds:
  - state_t enum {IDLE, CALC, HOLD};
  - localparam helper CNT_W = $clog2(WIDTH) as a function of WIDTH.
- One sub-module, add_sub_n:
  - parameter N; inputs a[N-1:0], b[N-1:0], sub, ext_signed; output sum[N:0].
  - Purely combinational; instantiated once with N=WIDTH.

Test Plan:
- WIDTH=8, Load_Clear with Din=8'hC5, then Run rise with Din=8'h07 → Done 9 clocks after the Run rise; Prod=16'hFE63 (−413), Xval=1.
- Chain: after the case above, release Run, raise Run with Din=8'h07 → Prod=16'h02B5 (99×7). Repeat → Prod=16'hFDF3 (−75×7).
- Load B=8'h80, Run with Din=8'h80 → Prod=16'h4000. Load B=8'h00, Run with Din=8'hFF → Prod=16'h0000.
- Reset asserted 3 clocks into CALC → the next clock has all outputs 0 and state IDLE. Run still high after Reset drops → no restart until Run falls and rises again.
- Run held high 20 clocks → exactly one Done pulse. Load_Clear pulsed during CALC → no effect on B; result unchanged.
- WIDTH=4: B=4'h9, S=4'h3 → Prod=8'hEB (−21). With MULT_SIGNED_SELECT_EN, WIDTH=8, Signed_Mode=0: B=8'hFF, S=8'hFF → Prod=16'hFE01.
